// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg: shared types for the PE sequencer.
//   state_t - job FSM states
//   TAG_*   - IFM word tags, {first_of_row, last_of_row}
package pe_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD_FIL,
    ST_LOAD_IFM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_LAST   = 2'b01;
  localparam logic [1:0] TAG_FIRST  = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  function automatic logic [1:0] row_tag(input logic first, input logic last);
    if (first && last) return TAG_SINGLE;
    if (first)         return TAG_FIRST;
    if (last)          return TAG_LAST;
    return TAG_MID;
  endfunction

endpackage

// File: rtl/pe_sched_rowcnt.sv
// pe_sched_rowcnt: column/row counter pair for IFM streaming.
//   clk, rst_n          clock, async active-low reset
//   clr                 zero both counters (wins over adv)
//   adv                 one IFM word transferred this cycle
//   row_len, num_rows   job geometry
//   tag                 tag for the word currently offered
//   last_word           current word is the last word of the last row
module pe_sched_rowcnt
  import pe_sched_pkg::*;
#(
  parameter int ROW_W  = 8,
  parameter int NROW_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [ROW_W-1:0]  row_len,
  input  logic [NROW_W-1:0] num_rows,
  output logic [1:0]        tag,
  output logic              last_word
);

  logic [ROW_W-1:0]  col;
  logic [NROW_W-1:0] row;
  logic              col_last;
  logic              row_last;

  assign col_last  = (col == row_len - ROW_W'(1));
  assign row_last  = (row == num_rows - NROW_W'(1));
  assign last_word = col_last && row_last;
  assign tag       = row_tag(col == '0, col_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        row <= row + NROW_W'(1);
      end else begin
        col <= col + ROW_W'(1);
      end
    end
  end

endmodule

// File: rtl/pe_sched.sv
// pe_sched: job sequencer for one convolution PE.
//   cfg_*            job config, latched on cfg_go in IDLE
//   abort            return to IDLE from any active state, no done
//   fil_* / ifm_*    source streams, passed through to the PE write ports
//   pe_*             PE control, write and read ports
//   out_*            result stream drained from the PE read port
//   busy / done      job activity / one-cycle completion pulse
// Stream handshakes are combinational gates keyed off the registered state,
// so every output is zero while in reset or outside its active state.
module pe_sched
  import pe_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int S          = 3,
  parameter int F          = 3,
  parameter int ROW_W      = 8,
  parameter int NROW_W     = 8,
  parameter int OUT_W      = 2*DATA_WIDTH-1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_go,
  input  logic                    abort,
  input  logic [S-1:0]            cfg_stride,
  input  logic [F-1:0]            cfg_filter_size,
  input  logic [1:0]              cfg_mode,
  input  logic [ROW_W-1:0]        cfg_row_len,
  input  logic [NROW_W-1:0]       cfg_num_rows,
  input  logic [ROW_W+NROW_W-1:0] cfg_out_cnt,
  input  logic [DATA_WIDTH-1:0]   fil_data,
  input  logic                    fil_valid,
  output logic                    fil_ready,
  input  logic [DATA_WIDTH-1:0]   ifm_data,
  input  logic                    ifm_valid,
  output logic                    ifm_ready,
  output logic                    pe_start,
  output logic [S-1:0]            pe_stride,
  output logic [F-1:0]            pe_filter_size,
  output logic [1:0]              pe_mode,
  output logic                    pe_w_en_fil,
  output logic [DATA_WIDTH-1:0]   pe_data_fil,
  input  logic                    pe_ready_fil,
  output logic                    pe_w_en_ifm,
  output logic [DATA_WIDTH+1:0]   pe_data_ifm,
  input  logic                    pe_ready_ifm,
  output logic                    pe_r_en,
  input  logic [OUT_W-1:0]        pe_out,
  input  logic                    pe_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = ROW_W + NROW_W;

  state_t            state;
  logic [ROW_W-1:0]  row_len_q;
  logic [NROW_W-1:0] num_rows_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [F-1:0]      fil_cnt;
  logic [CNT_W-1:0]  rd_cnt;

  logic in_fil, in_ifm, in_drain;
  logic fil_xfer, ifm_xfer, rd_xfer;
  logic [1:0] ifm_tag;
  logic ifm_last;
  state_t after_ifm, after_fil, after_start;

  assign in_fil   = (state == ST_LOAD_FIL);
  assign in_ifm   = (state == ST_LOAD_IFM);
  assign in_drain = (state == ST_DRAIN);

  assign fil_ready   = in_fil && pe_ready_fil;
  assign pe_w_en_fil = in_fil && fil_valid && pe_ready_fil;
  assign pe_data_fil = in_fil ? fil_data : '0;
  assign fil_xfer    = pe_w_en_fil;

  assign ifm_ready   = in_ifm && pe_ready_ifm;
  assign pe_w_en_ifm = in_ifm && ifm_valid && pe_ready_ifm;
  assign pe_data_ifm = in_ifm ? {ifm_tag, ifm_data} : '0;
  assign ifm_xfer    = pe_w_en_ifm;

  assign pe_r_en   = in_drain && out_ready;
  assign out_valid = in_drain && pe_valid;
  assign out_data  = in_drain ? pe_out : '0;
  assign rd_xfer   = pe_r_en && pe_valid;

  assign pe_start = (state == ST_START);
  assign done     = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);

  // Zero-length phases are skipped; resolve the chain back to front so each
  // exit goes straight to the next phase that has work.
  always_comb begin
    after_ifm   = (out_cnt_q == '0) ? ST_DONE : ST_DRAIN;
    after_fil   = (row_len_q == '0 || num_rows_q == '0) ? after_ifm : ST_LOAD_IFM;
    after_start = (pe_filter_size == '0) ? after_fil : ST_LOAD_FIL;
  end

  // Counters are held clear outside LOAD_IFM, and abort clears them.
  pe_sched_rowcnt #(.ROW_W(ROW_W), .NROW_W(NROW_W)) u_rowcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!in_ifm || abort),
    .adv       (ifm_xfer),
    .row_len   (row_len_q),
    .num_rows  (num_rows_q),
    .tag       (ifm_tag),
    .last_word (ifm_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pe_stride      <= '0;
      pe_filter_size <= '0;
      pe_mode        <= '0;
      row_len_q      <= '0;
      num_rows_q     <= '0;
      out_cnt_q      <= '0;
      fil_cnt        <= '0;
      rd_cnt         <= '0;
    end else if (abort && state != ST_IDLE) begin
      state   <= ST_IDLE;
      fil_cnt <= '0;
      rd_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cfg_go) begin
          pe_stride      <= cfg_stride;
          pe_filter_size <= cfg_filter_size;
          pe_mode        <= cfg_mode;
          row_len_q      <= cfg_row_len;
          num_rows_q     <= cfg_num_rows;
          out_cnt_q      <= cfg_out_cnt;
          fil_cnt        <= '0;
          rd_cnt         <= '0;
          state          <= ST_START;
        end
        ST_START: state <= after_start;
        ST_LOAD_FIL: if (fil_xfer) begin
          if (fil_cnt == pe_filter_size - F'(1)) begin
            fil_cnt <= '0;
            state   <= after_fil;
          end else begin
            fil_cnt <= fil_cnt + F'(1);
          end
        end
        ST_LOAD_IFM: if (ifm_xfer && ifm_last) state <= after_ifm;
        ST_DRAIN: if (rd_xfer) begin
          if (rd_cnt == out_cnt_q - CNT_W'(1)) begin
            rd_cnt <= '0;
            state  <= ST_DONE;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sched.sv
module tb_pe_sched;

  localparam int DW = 16;
  localparam int OW = 2*DW-1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_go = 1'b0, abort = 1'b0;
  logic [2:0]    cfg_stride = '0, cfg_filter_size = '0;
  logic [1:0]    cfg_mode = '0;
  logic [7:0]    cfg_row_len = '0, cfg_num_rows = '0;
  logic [15:0]   cfg_out_cnt = '0;
  logic [DW-1:0] fil_data = '0, ifm_data = '0;
  logic          fil_valid = 1'b0, ifm_valid = 1'b0;
  logic          fil_ready, ifm_ready;
  logic          pe_start;
  logic [2:0]    pe_stride, pe_filter_size;
  logic [1:0]    pe_mode;
  logic          pe_w_en_fil, pe_w_en_ifm, pe_r_en;
  logic [DW-1:0] pe_data_fil;
  logic [DW+1:0] pe_data_ifm;
  logic          pe_ready_fil = 1'b0, pe_ready_ifm = 1'b0;
  logic [OW-1:0] pe_out = '0, out_data;
  logic          pe_valid = 1'b0, out_valid, out_ready = 1'b0;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_go(cfg_go), .abort(abort),
    .cfg_stride(cfg_stride), .cfg_filter_size(cfg_filter_size), .cfg_mode(cfg_mode),
    .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows), .cfg_out_cnt(cfg_out_cnt),
    .fil_data(fil_data), .fil_valid(fil_valid), .fil_ready(fil_ready),
    .ifm_data(ifm_data), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
    .pe_start(pe_start), .pe_stride(pe_stride), .pe_filter_size(pe_filter_size),
    .pe_mode(pe_mode), .pe_w_en_fil(pe_w_en_fil), .pe_data_fil(pe_data_fil),
    .pe_ready_fil(pe_ready_fil), .pe_w_en_ifm(pe_w_en_ifm), .pe_data_ifm(pe_data_ifm),
    .pe_ready_ifm(pe_ready_ifm), .pe_r_en(pe_r_en), .pe_out(pe_out), .pe_valid(pe_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  typedef struct {
    int f; int rl; int nr; int oc; int stride; int mode; int thr;
    int exp_fw; int exp_iw; int exp_rd; int exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Tag of the i-th IFM word of a job: {first_of_row, last_of_row}.
  function automatic logic [1:0] exp_tag(input int i, input int rl);
    int c;
    c = i % rl;
    return {c == 0, c == rl - 1};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_start"},    pe_start, 0);
    chk({tag, "_rdys"},     {fil_ready, ifm_ready}, 0);
    chk({tag, "_wen"},      {pe_w_en_fil, pe_w_en_ifm, pe_r_en}, 0);
    chk({tag, "_ovalid"},   out_valid, 0);
    chk({tag, "_cfg"},      {pe_stride, pe_filter_size, pe_mode}, 0);
    chk({tag, "_data"},     {pe_data_fil, pe_data_ifm, out_data}, 0);
  endtask

  task automatic start_job(input vec_t v);
    @(posedge clk); #1;
    cfg_filter_size = 3'(v.f);  cfg_row_len = 8'(v.rl);  cfg_num_rows = 8'(v.nr);
    cfg_out_cnt = 16'(v.oc);    cfg_stride = 3'(v.stride); cfg_mode = 2'(v.mode);
    cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input string nm);
    int cyc, fw, iw, rd, nstart, ndone, nren, lat, tagerr, daterr, viol;
    logic [DW+1:0] expw;
    cyc = 0; fw = 0; iw = 0; rd = 0; nstart = 0; ndone = 0; nren = 0;
    lat = -1; tagerr = 0; daterr = 0; viol = 0;
    start_job(v);
    while (lat < 0 && cyc < 300) begin
      pe_ready_fil = 1'b1; out_ready = 1'b1; pe_valid = 1'b1; fil_valid = 1'b1;
      pe_ready_ifm = (v.thr != 0) ? (cyc % 2 == 0) : 1'b1;
      ifm_valid    = (v.thr != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      fil_data = DW'(5 + fw);
      ifm_data = DW'(100 + iw);
      pe_out   = OW'(1000 + rd);
      @(negedge clk);
      if (pe_start) nstart++;
      if (pe_w_en_fil) begin
        if (pe_data_fil !== DW'(5 + fw)) daterr++;
        fw++;
      end
      if (pe_w_en_ifm) begin
        if (!pe_ready_ifm || !ifm_valid) viol++;
        expw = {exp_tag(iw, v.rl), DW'(100 + iw)};
        if (pe_data_ifm !== expw) tagerr++;
        iw++;
      end
      if (pe_r_en) nren++;
      if (pe_r_en && pe_valid) begin
        if (out_data !== OW'(1000 + rd)) daterr++;
        rd++;
      end
      if (done) begin ndone++; lat = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    chk({nm, "_done_seen"}, lat >= 0, 1);
    chk({nm, "_starts"},   nstart, 1);
    chk({nm, "_fil_wr"},   fw, v.exp_fw);
    chk({nm, "_ifm_wr"},   iw, v.exp_iw);
    chk({nm, "_reads"},    rd, v.exp_rd);
    chk({nm, "_r_en"},     nren, v.exp_rd);
    chk({nm, "_tag_err"},  tagerr, 0);
    chk({nm, "_data_err"}, daterr, 0);
    chk({nm, "_hs_viol"},  viol, 0);
    if (v.exp_lat >= 0) chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_done_1cyc"}, done, 0);
    chk({nm, "_idle"},      busy, 0);
    chk({nm, "_cfg_keep"}, {pe_stride, pe_filter_size, pe_mode},
        {3'(v.stride), 3'(v.f), 2'(v.mode)});
  endtask

  initial begin : main
    vec_t v;
    int cyc, iw, rd, ndone, xstart, nbusy;

    //          f rl nr oc st md thr  fw iw rd lat
    vecs[0] = '{3, 6, 2, 16, 1, 0, 0,  3, 12, 16, 32};
    vecs[1] = '{3, 6, 2, 16, 2, 1, 1,  3, 12, 16, -1};
    vecs[2] = '{2, 1, 3,  2, 3, 2, 0,  2,  3,  2,  8};
    vecs[3] = '{0, 2, 1,  0, 4, 3, 0,  0,  2,  0,  3};
    vecs[4] = '{1, 0, 5,  3, 7, 1, 0,  1,  0,  3,  5};
    vecs[5] = '{0, 0, 0,  0, 0, 0, 0,  0,  0,  0,  1};

    // Reset state, with every source offering so gating is exercised.
    fil_valid = 1'b1; ifm_valid = 1'b1; pe_ready_fil = 1'b1; pe_ready_ifm = 1'b1;
    pe_valid = 1'b1; out_ready = 1'b1; pe_out = OW'(77); ifm_data = DW'(9); fil_data = DW'(9);
    repeat (3) @(posedge clk);
    #1; chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) run_job(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of row 1 of the IFM phase.
    v = '{1, 6, 2, 4, 5, 3, 0, 0, 0, 0, 0};
    start_job(v);
    fil_valid = 1'b1; ifm_valid = 1'b1; pe_ready_fil = 1'b1; pe_ready_ifm = 1'b1;
    iw = 0; cyc = 0;
    while (iw < 10 && cyc < 100) begin
      ifm_data = DW'(100 + iw);
      @(negedge clk);
      if (pe_w_en_ifm) iw++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_ifm_reached", iw, 10);
    #1;
    chk("mid_ifm_tag", pe_data_ifm[DW+1:DW], 2'b00);
    rst_n = 1'b0;
    #1; chk_all_zero("midrst");
    @(negedge clk); rst_n = 1'b1;
    run_job('{0, 6, 1, 1, 2, 2, 0, 0, 6, 1, 8}, "restart");

    // Abort after 5 drain reads; a second cfg_go during LOAD_FIL is ignored.
    v = '{3, 2, 1, 10, 5, 2, 0, 0, 0, 0, 0};
    start_job(v);
    rd = 0; ndone = 0; xstart = 0; cyc = 0;
    while (rd < 5 && cyc < 100) begin
      fil_valid = 1'b1; ifm_valid = 1'b1; pe_ready_fil = 1'b1; pe_ready_ifm = 1'b1;
      pe_valid = 1'b1; out_ready = 1'b1;
      if (cyc == 1) begin
        cfg_go = 1'b1; cfg_stride = 3'd1; cfg_filter_size = 3'd7; cfg_mode = 2'd1;
        cfg_out_cnt = 16'd2;
      end else begin
        cfg_go = 1'b0;
      end
      @(negedge clk);
      if (cyc > 0 && pe_start) xstart++;
      if (pe_r_en && pe_valid) rd++;
      if (done) ndone++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reads_before", rd, 5);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_inflight_r_en", pe_r_en, 1);
    if (done) ndone++;
    @(posedge clk); #1;
    abort = 1'b0;
    nbusy = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", nbusy, 0);
    chk("abort_no_restart", xstart, 0);
    chk("abort_cfg_kept", {pe_stride, pe_filter_size, pe_mode}, {3'd5, 3'd3, 2'd2});
    run_job('{1, 1, 1, 2, 6, 1, 0, 1, 1, 2, 5}, "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
